mmio_uart_tx: RTL

//  Memory-mapped UART transmitter on the core's data-memory bus, beside dmem; it consumes

---
 rtl/mmio_uart_tx_if.sv | 25 ++
 rtl/mmio_uart_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the MMIO UART transmitter: store strobe, address, data,
// plus the combinational select and read-data returned to the core's load mux.
interface mmio_uart_tx_if;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_sel;
    logic [31:0] bus_rdata;

    modport master (
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_sel,
        input  bus_rdata
    );

    modport slave (
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_sel,
        output bus_rdata
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a 16-byte register window on the data bus feeds a
// byte FIFO that a small FSM drains onto the registered tx pin.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter logic [15:0] DIV_RESET  = 16'd233,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mmio_uart_tx_if.slave        bus,
    output logic                 tx,
    output logic                 irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]  fifo_mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] bit_div_q, bit_div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;

    logic [1:0]  offset;
    logic        empty;
    logic        full;
    logic        busy;
    logic        push_req;
    logic        push;
    logic        wr_status;
    logic        wr_div;
    logic        unused_bus;

    assign bus.bus_sel = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
    assign offset      = bus.bus_addr[3:2];
    assign unused_bus  = ^{bus.bus_addr[1:0], bus.bus_wdata[31:16]};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign busy  = (state_q != S_IDLE);

    assign push_req  = bus.bus_we & bus.bus_sel & (offset == 2'd0);
    assign push      = push_req & ~full;
    assign wr_status = bus.bus_we & bus.bus_sel & (offset == 2'd1);
    assign wr_div    = bus.bus_we & bus.bus_sel & (offset == 2'd2);

    assign tx  = tx_q;
    assign irq = irq_q;

    always_comb begin
        bus.bus_rdata = 32'h0;
        if (bus.bus_sel) begin
            case (offset)
                2'd1:    bus.bus_rdata = {27'b0, ovf_q, empty, full, busy, 1'b0};
                2'd2:    bus.bus_rdata = {16'b0, div_q};
                default: bus.bus_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        // A set in the same cycle as a clear leaves ovf asserted.
        ovf_d = ovf_q;
        if (wr_status && bus.bus_wdata[4]) begin
            ovf_d = 1'b0;
        end
        if (push_req && full) begin
            ovf_d = 1'b1;
        end

        div_d = div_q;
        if (wr_div) begin
            div_d = (bus.bus_wdata[15:0] == 16'd0) ? 16'd1 : bus.bus_wdata[15:0];
        end
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        state_d   = state_q;
        shift_d   = shift_q;
        bit_div_d = bit_div_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    shift_d   = fifo_mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    bit_div_d = div_q;
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == bit_div_q) begin
                    cnt_d   = 16'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == bit_div_q) begin
                    cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == bit_div_q) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        irq_d = empty & (state_q == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= bus.bus_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            div_q     <= DIV_RESET;
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            bit_div_q <= 16'd0;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_div_q <= bit_div_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
        end
    end

endmodule
